// File: rtl/sd_wb_slave.sv
// rtl/sd_wb_slave.sv - Wishbone classic slave front-end of the SD host controller
// Define SD_WB_SLAVE_IRQ_EN to add sticky completion interrupts and the irq_o port.
module sd_wb_slave #(
  parameter int DATA_W = 128,
  parameter int ADR_W  = 5
) (
  input  logic              wb_clock,
  input  logic              reset,
  input  logic              strobe_i,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              ack_o,
  output logic              error_o,
  output logic              cmd_start_o,
  output logic              data_start_o,
  input  logic              cmd_done_i,
  input  logic              data_done_i,
  output logic              cmd_busy_o,
  output logic              data_busy_o,
  output logic [DATA_W-1:0] cmd_arg_o,
  output logic [DATA_W-1:0] data_cfg_o,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_wr_data_o,
  input  logic              fifo_full_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  input  logic              fifo_empty_i
`ifdef SD_WB_SLAVE_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FIFO_RD = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam int unsigned ADR_CMD  = 16;
  localparam int unsigned ADR_FWR  = 17;
  localparam int unsigned ADR_FRD  = 18;
  localparam int unsigned ADR_DAT  = 19;
  localparam int unsigned ADR_IRQC = 15;

  logic [1:0]        state;
  logic [DATA_W-1:0] regs [16];

  int unsigned       adr;
  logic              take;
  logic              acc_err;
  logic              reg_wr;
  logic              rd_reg;
  logic              rd_status;
  logic              cmd_go;
  logic              data_go;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] status;

`ifdef SD_WB_SLAVE_IRQ_EN
  logic cmd_irq;
  logic data_irq;
  logic irq_clr;
  logic cmd_irq_nxt;
  logic data_irq_nxt;
`endif

  // Decode only while idle; every request is classified as exactly one action or an error.
  always_comb begin
    adr       = 32'(adr_i);
    take      = (state == IDLE) && strobe_i;
    acc_err   = 1'b0;
    reg_wr    = 1'b0;
    rd_reg    = 1'b0;
    rd_status = 1'b0;
    cmd_go    = 1'b0;
    data_go   = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    status    = '0;
    status[0] = cmd_busy_o;
    status[1] = data_busy_o;
`ifdef SD_WB_SLAVE_IRQ_EN
    status[2] = cmd_irq;
    status[3] = data_irq;
`endif
    if (take) begin
      if (adr < ADR_CMD) begin
        reg_wr = we_i;
        rd_reg = !we_i;
      end else if (adr == ADR_CMD) begin
        if (!we_i)           rd_status = 1'b1;
        else if (cmd_busy_o) acc_err   = 1'b1;
        else                 cmd_go    = 1'b1;
      end else if (adr == ADR_DAT) begin
        if (!we_i)            rd_status = 1'b1;
        else if (data_busy_o) acc_err   = 1'b1;
        else                  data_go   = 1'b1;
      end else if (adr == ADR_FWR) begin
        if (we_i && !fifo_full_i) fifo_push = 1'b1;
        else                      acc_err   = 1'b1;
      end else if (adr == ADR_FRD) begin
        if (!we_i && !fifo_empty_i) fifo_pop = 1'b1;
        else                        acc_err  = 1'b1;
      end else begin
        acc_err = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_wr) begin
      regs[adr_i[3:0]] <= wb_data_i;
    end
  end

  assign cmd_arg_o  = regs[0];
  assign data_cfg_o = regs[1];

  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ack_o          <= 1'b0;
      error_o        <= 1'b0;
      cmd_start_o    <= 1'b0;
      data_start_o   <= 1'b0;
      cmd_busy_o     <= 1'b0;
      data_busy_o    <= 1'b0;
      fifo_wr_en_o   <= 1'b0;
      fifo_rd_en_o   <= 1'b0;
      wb_data_o      <= '0;
      fifo_wr_data_o <= '0;
    end else begin
      cmd_start_o  <= cmd_go;
      data_start_o <= data_go;
      fifo_wr_en_o <= fifo_push;
      fifo_rd_en_o <= fifo_pop;

      // A start can only be accepted with the flag clear, so it safely overrides a done.
      if (cmd_go)           cmd_busy_o <= 1'b1;
      else if (cmd_done_i)  cmd_busy_o <= 1'b0;
      if (data_go)          data_busy_o <= 1'b1;
      else if (data_done_i) data_busy_o <= 1'b0;

      if (fifo_push) fifo_wr_data_o <= wb_data_i;

      if (rd_reg)                wb_data_o <= regs[adr_i[3:0]];
      else if (rd_status)        wb_data_o <= status;
      else if (state == FIFO_RD) wb_data_o <= fifo_rd_data_i;

      case (state)
        IDLE: begin
          if (strobe_i) begin
            if (fifo_pop) begin
              state <= FIFO_RD;
            end else begin
              state   <= RESP;
              ack_o   <= !acc_err;
              error_o <= acc_err;
            end
          end
        end
        FIFO_RD: begin
          ack_o <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          ack_o   <= 1'b0;
          error_o <= 1'b0;
          state   <= RELEASE;
        end
        default: begin
          if (!strobe_i) state <= IDLE;
        end
      endcase
    end
  end

`ifdef SD_WB_SLAVE_IRQ_EN
  // Busy only falls on a done pulse while set; a same-edge clear loses to a new completion.
  assign irq_clr      = reg_wr && (adr == ADR_IRQC);
  assign cmd_irq_nxt  = (cmd_irq & ~irq_clr) | (cmd_busy_o & cmd_done_i);
  assign data_irq_nxt = (data_irq & ~irq_clr) | (data_busy_o & data_done_i);

  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      cmd_irq  <= 1'b0;
      data_irq <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      cmd_irq  <= cmd_irq_nxt;
      data_irq <= data_irq_nxt;
      irq_o    <= cmd_irq_nxt | data_irq_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sd_wb_slave.sv
// tb/tb_sd_wb_slave.sv - self-checking bench for sd_wb_slave
// Exercises SD_WB_SLAVE_IRQ_EN behaviour when the macro is defined.
module tb_sd_wb_slave;

`ifdef SD_WB_SLAVE_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         strobe = 1'b0;
  logic         we = 1'b0;
  logic [4:0]   adr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] wb_data_o;
  logic         ack_o, error_o, cmd_start_o, data_start_o;
  logic         cmd_done = 1'b0, data_done = 1'b0;
  logic         cmd_busy_o, data_busy_o;
  logic [127:0] cmd_arg_o, data_cfg_o, fifo_wr_data_o;
  logic         fifo_wr_en_o, fifo_rd_en_o;
  logic         fifo_full = 1'b0, fifo_empty = 1'b1;
  logic [127:0] fifo_rd_data = '0;
`ifdef SD_WB_SLAVE_IRQ_EN
  logic         irq;
`endif

  sd_wb_slave dut (
    .wb_clock(clk), .reset(rst_n), .strobe_i(strobe), .we_i(we), .adr_i(adr),
    .wb_data_i(wdata), .wb_data_o(wb_data_o), .ack_o(ack_o), .error_o(error_o),
    .cmd_start_o(cmd_start_o), .data_start_o(data_start_o),
    .cmd_done_i(cmd_done), .data_done_i(data_done),
    .cmd_busy_o(cmd_busy_o), .data_busy_o(data_busy_o),
    .cmd_arg_o(cmd_arg_o), .data_cfg_o(data_cfg_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_data_o(fifo_wr_data_o), .fifo_full_i(fifo_full),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_data_i(fifo_rd_data), .fifo_empty_i(fifo_empty)
`ifdef SD_WB_SLAVE_IRQ_EN
    , .irq_o(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Transaction-level reference: a request is accepted once the bus has been idle since the
  // previous response; the reply appears one cycle later (two for a FIFO pop).
  logic [127:0] m_reg [16];
  logic [127:0] m_wbd = '0, m_wrd = '0;
  logic m_ack = 0, m_err = 0, m_cs = 0, m_ds = 0, m_wen = 0, m_ren = 0;
  logic m_cb = 0, m_db = 0, m_cirq = 0, m_dirq = 0, m_ready = 1, m_pend = 0;
  logic old_cb, old_db, old_ci, old_di, was_resp, ok;
  int   a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_wbd = '0; m_wrd = '0;
      {m_ack, m_err, m_cs, m_ds, m_wen, m_ren, m_cb, m_db, m_cirq, m_dirq, m_pend} = '0;
      m_ready = 1;
    end else begin
      was_resp = m_ack | m_err;
      old_cb = m_cb; old_db = m_db; old_ci = m_cirq; old_di = m_dirq;
      {m_ack, m_err, m_cs, m_ds, m_wen, m_ren} = '0;
      if (cmd_done)  m_cb = 0;
      if (data_done) m_db = 0;
      if (m_pend) begin
        m_wbd = fifo_rd_data; m_ack = 1; m_pend = 0;
      end else if (m_ready && strobe) begin
        m_ready = 0; a = int'(adr); ok = 1;
        if (a < 16) begin
          if (we) begin
            m_reg[a] = wdata;
            if (a == 15 && IRQ_ON == 1) begin m_cirq = 0; m_dirq = 0; end
          end else m_wbd = m_reg[a];
        end else if (a == 16 || a == 19) begin
          if (!we) m_wbd = 128'(old_cb) + 2 * 128'(old_db) + (IRQ_ON == 1 ? 4 * 128'(old_ci) + 8 * 128'(old_di) : 128'(0));
          else if (a == 16 && old_cb) ok = 0;
          else if (a == 19 && old_db) ok = 0;
          else if (a == 16) begin m_cs = 1; m_cb = 1; end
          else begin m_ds = 1; m_db = 1; end
        end else if (a == 17) begin
          if (we && !fifo_full) begin m_wen = 1; m_wrd = wdata; end else ok = 0;
        end else if (a == 18) begin
          if (!we && !fifo_empty) begin m_ren = 1; m_pend = 1; end else ok = 0;
        end else ok = 0;
        m_ack = ok && !m_pend;
        m_err = !ok;
      end else if (!m_ready && !was_resp && !strobe) begin
        m_ready = 1;
      end
      if (old_cb && cmd_done)  m_cirq = 1;
      if (old_db && data_done) m_dirq = 1;
    end
  end

  logic cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ack_o", ack_o, m_ack);
      chk("error_o", error_o, m_err);
      chk("cmd_start_o", cmd_start_o, m_cs);
      chk("data_start_o", data_start_o, m_ds);
      chk("cmd_busy_o", cmd_busy_o, m_cb);
      chk("data_busy_o", data_busy_o, m_db);
      chk("fifo_wr_en_o", fifo_wr_en_o, m_wen);
      chk("fifo_rd_en_o", fifo_rd_en_o, m_ren);
      chk("wb_data_o", wb_data_o, m_wbd);
      chk("fifo_wr_data_o", fifo_wr_data_o, m_wrd);
      chk("cmd_arg_o", cmd_arg_o, m_reg[0]);
      chk("data_cfg_o", data_cfg_o, m_reg[1]);
`ifdef SD_WB_SLAVE_IRQ_EN
      chk("irq_o", irq, m_cirq | m_dirq);
`endif
    end
  end

  int c_ack = 0, c_err = 0, c_cs = 0, c_ds = 0, c_wen = 0, c_ren = 0;
  always @(negedge clk) begin
    c_ack = c_ack + int'(ack_o);
    c_err = c_err + int'(error_o);
    c_cs  = c_cs + int'(cmd_start_o);
    c_ds  = c_ds + int'(data_start_o);
    c_wen = c_wen + int'(fifo_wr_en_o);
    c_ren = c_ren + int'(fifo_rd_en_o);
  end

  int r_lat; logic r_ack, r_err; logic [127:0] r_data;

  task automatic xfer(input logic w, input int ad, input logic [127:0] d, input logic [1:0] dn);
    @(negedge clk);
    strobe = 1; we = w; adr = 5'(ad); wdata = d;
    cmd_done = dn[0]; data_done = dn[1];
    r_lat = 0; r_ack = 0; r_err = 0; r_data = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      cmd_done = 0; data_done = 0;
      if (ack_o || error_o) begin
        r_lat = i; r_ack = ack_o; r_err = error_o; r_data = wb_data_o;
        break;
      end
    end
    chk("response_seen", r_lat != 0, 1'b1);
    strobe = 0;
    @(negedge clk); @(negedge clk); #1;
  endtask

  task automatic expect_resp(input string nm, input int lat, input logic is_ack);
    chk(nm, {r_lat[7:0], 3'b0, r_ack, 3'b0, r_err}, {lat[7:0], 3'b0, is_ack, 3'b0, !is_ack});
  endtask

  task automatic pulse_done(input logic [1:0] dn);
    @(negedge clk); cmd_done = dn[0]; data_done = dn[1];
    @(negedge clk); cmd_done = 0; data_done = 0;
    @(negedge clk); #1;
  endtask

  int s0, s1;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_wb_data", wb_data_o, '0);
    chk("rst_cmd_busy", cmd_busy_o, 1'b0);
    chk("rst_fifo_wr_data", fifo_wr_data_o, '0);
    cmp_en = 1;
    rst_n = 1;

    xfer(1, 3, 128'hA5, 2'b00);   expect_resp("wr3", 1, 1);
    xfer(0, 3, '0, 2'b00);        expect_resp("rd3", 1, 1);
    chk("rd3_data", r_data, 128'hA5);
    chk("cmd_arg_still0", cmd_arg_o, '0);
    xfer(1, 0, 128'h11, 2'b00);   chk("cmd_arg", cmd_arg_o, 128'h11);
    xfer(1, 1, 128'h22, 2'b00);   chk("data_cfg", data_cfg_o, 128'h22);
    xfer(0, 3, '0, 2'b00);        chk("wb_data_kept_after_writes", r_data, 128'hA5);

    s0 = c_cs;
    xfer(1, 16, '0, 2'b00);       expect_resp("cmd_exec", 1, 1);
    chk("cmd_start_once", c_cs - s0, 1);
    chk("cmd_busy_set", cmd_busy_o, 1'b1);
    xfer(0, 16, '0, 2'b00);       chk("status_cmd_busy", r_data, 128'h1);
    s0 = c_cs;
    xfer(1, 16, '0, 2'b00);       expect_resp("cmd_exec_busy", 1, 0);
    chk("cmd_no_start", c_cs - s0, 0);
    pulse_done(2'b01);            chk("cmd_busy_clr", cmd_busy_o, 1'b0);
    xfer(0, 16, '0, 2'b00);       chk("status_idle", r_data, 128'(4 * IRQ_ON));

    xfer(1, 16, '0, 2'b01);       expect_resp("start_wins", 1, 1);
    chk("start_wins_busy", cmd_busy_o, 1'b1);
    xfer(1, 16, '0, 2'b01);       expect_resp("busy_done_same_edge", 1, 0);
    chk("busy_done_clears", cmd_busy_o, 1'b0);

    xfer(1, 19, '0, 2'b00);       expect_resp("data_exec", 1, 1);
    xfer(0, 19, '0, 2'b00);       chk("status_data_busy", r_data, 128'(2 + 4 * IRQ_ON));
    pulse_done(2'b10);            chk("data_busy_clr", data_busy_o, 1'b0);

    fifo_full = 1; s0 = c_wen;
    xfer(1, 17, 128'h55, 2'b00);  expect_resp("fifo_wr_full", 1, 0);
    chk("fifo_wr_blocked", c_wen - s0, 0);
    fifo_full = 0; s0 = c_wen;
    xfer(1, 17, 128'h55, 2'b00);  expect_resp("fifo_wr", 1, 1);
    chk("fifo_wr_once", c_wen - s0, 1);
    chk("fifo_wr_data", fifo_wr_data_o, 128'h55);

    fifo_empty = 0; fifo_rd_data = 128'h1234; s0 = c_ren;
    xfer(0, 18, '0, 2'b00);       expect_resp("fifo_rd", 2, 1);
    chk("fifo_rd_once", c_ren - s0, 1);
    chk("fifo_rd_data", r_data, 128'h1234);
    fifo_empty = 1;
    xfer(0, 18, '0, 2'b00);       expect_resp("fifo_rd_empty", 1, 0);

    xfer(1, 21, 128'h9, 2'b00);   expect_resp("adr21_wr", 1, 0);
    xfer(0, 20, '0, 2'b00);       expect_resp("adr20_rd", 1, 0);
    xfer(0, 17, '0, 2'b00);       expect_resp("adr17_rd", 1, 0);
    xfer(1, 18, '0, 2'b00);       expect_resp("adr18_wr", 1, 0);

    s0 = c_ack; s1 = c_err;
    @(negedge clk); strobe = 1; we = 0; adr = 5'd3;
    repeat (5) @(negedge clk);
    strobe = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("held_strobe_one_resp", (c_ack - s0) + (c_err - s1), 1);

    @(negedge clk); strobe = 1; we = 1; adr = 5'd19; wdata = '0;
    @(negedge clk);
    chk("rm_ack_pre", {ack_o, data_start_o, data_busy_o}, 3'b111);
    #1 rst_n = 0; strobe = 0;
    #1 chk("rm_outputs_dropped", {ack_o, error_o, data_start_o, data_busy_o}, 4'b0000);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    chk("rm_regs_cleared", cmd_arg_o, '0);
    xfer(0, 3, '0, 2'b00);        chk("rm_reg3_cleared", r_data, '0);

`ifdef SD_WB_SLAVE_IRQ_EN
    chk("irq_after_reset", irq, 1'b0);
    xfer(1, 19, '0, 2'b00);       chk("irq_busy_no_irq", irq, 1'b0);
    pulse_done(2'b10);            chk("irq_set", irq, 1'b1);
    xfer(0, 19, '0, 2'b00);       chk("irq_status", r_data, 128'h8);
    xfer(1, 15, 128'h77, 2'b00);  chk("irq_cleared", irq, 1'b0);
    xfer(0, 15, '0, 2'b00);       chk("reg15_stored", r_data, 128'h77);
`endif

    repeat (2) @(negedge clk);
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_wb_slave.md
Name: sd_wb_slave

Overview:
- Wishbone classic slave front-end of the SD host controller.
- Sits directly downstream of the Wishbone master and consumes its strobe/we/address/data transactions.
- Decodes the 5-bit address into:
  - adr 0-15: register file
  - adr 16: command execute
  - adr 17: FIFO write
  - adr 18: FIFO read
  - adr 19: data execute
- Returns a single-cycle ack_o or error_o per transaction and tracks the cmd/data busy state from the done strobes.

Parameters:
- DATA_W, 128, width of the Wishbone data buses, the registers and the FIFO data.
- ADR_W, 5, address width. Decode is fixed at 0-19; 20 to 2^ADR_W-1 are invalid.

Ports:
- wb_clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- strobe_i  in  1  transaction request.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADR_W  target address.
- wb_data_i  in  DATA_W  write data.
- wb_data_o  out  DATA_W  read data, valid while ack_o = 1.
- ack_o  out  1  transaction completed.
- error_o  out  1  transaction rejected.
- cmd_start_o  out  1  one-cycle command launch pulse.
- data_start_o  out  1  one-cycle data launch pulse.
- cmd_done_i  in  1  command engine finished.
- data_done_i  in  1  data engine finished.
- cmd_busy_o  out  1  command in flight.
- data_busy_o  out  1  data transfer in flight.
- cmd_arg_o  out  DATA_W  register 0 contents.
- data_cfg_o  out  DATA_W  register 1 contents.
- fifo_wr_en_o  out  1  FIFO push pulse.
- fifo_wr_data_o  out  DATA_W  FIFO push data.
- fifo_full_i  in  1  FIFO full.
- fifo_rd_en_o  out  1  FIFO pop pulse.
- fifo_rd_data_i  in  DATA_W  FIFO pop data, valid 1 cycle after fifo_rd_en_o.
- fifo_empty_i  in  1  FIFO empty.

Behaviour:
- Reset (reset = 0, immediate): every register-file entry = 0; wb_data_o = 0; fifo_wr_data_o = 0; all 1-bit outputs = 0; FSM = IDLE.
- All outputs are registered.
- FSM states: IDLE, FIFO_RD, RESP, RELEASE.
- IDLE:
  - strobe_i sampled 1 at edge N → decode and execute at edge N.
  - Go to RESP, so ack_o or error_o is high for exactly the cycle after edge N.
  - Exception: a valid FIFO read goes to FIFO_RD instead.
- Decode and action (an "error" result raises error_o in RESP instead of ack_o, and causes no side effect):
  - adr 0-15, write: register[adr] ← wb_data_i.
  - adr 0-15, read: wb_data_o ← register[adr].
  - adr 16, write:
    - if cmd_busy_o = 0: cmd_start_o = 1 for one cycle and cmd_busy_o ← 1;
    - else: error.
  - adr 16, read: wb_data_o ← {zeros, data_busy_o, cmd_busy_o}.
  - adr 19: same as adr 16, using data_start_o / data_busy_o.
  - adr 17, write:
    - if fifo_full_i = 0: fifo_wr_en_o = 1 for one cycle and fifo_wr_data_o ← wb_data_i;
    - else: error.
  - adr 17, read: error.
  - adr 18, read:
    - if fifo_empty_i = 0: fifo_rd_en_o = 1 for one cycle, go to FIFO_RD;
    - else: error.
  - adr 18, write: error.
  - adr ≥ 20: error.
- FIFO_RD: wb_data_o ← fifo_rd_data_i, then go to RESP. Read-FIFO ack latency is 2 cycles; all other accesses are 1 cycle.
- RESP: drop ack_o / error_o at the next edge and go to RELEASE.
- RELEASE: stay until strobe_i = 0, then go to IDLE. A strobe held high never retriggers.
- Busy flags:
  - cmd_done_i = 1 clears cmd_busy_o at the next edge, in any FSM state.
  - data_done_i does the same for data_busy_o.
  - A done pulse while the flag is already 0 is ignored.
- Simultaneous events:
  - Start accepted while done is asserted on the same edge with the flag at 0: the start wins, flag = 1.
  - Exec write while busy and done asserted on the same edge: error (the old flag value is used); the flag clears.
- wb_data_o holds its value outside read responses. Writes do not change it.
- Reset mid-transaction: the FSM returns to IDLE, all pulses drop, and any pending ack is lost.

Optional Feature:
- Macro: SD_WB_SLAVE_IRQ_EN.
- When defined:
  - Extra output irq_o (1 bit).
  - Two sticky bits, cmd_irq and data_irq, are set by the falling edge of cmd_busy_o and of data_busy_o respectively.
  - irq_o = cmd_irq | data_irq.
  - A write to adr 15 clears both sticky bits. The write also stores the data in register 15 as normal.
  - Reads of adr 16 and adr 19 return the sticky bits in bits [3:2].
- When undefined: no irq_o port, bits [3:2] read 0, and adr 15 is a plain register.

Test Plan:
- Release reset, write 0xA5 to adr 3, read adr 3 → ack_o high for 1 cycle after each strobe edge; the read returns wb_data_o = 0xA5; cmd_arg_o stays 0.
- Write adr 16 → cmd_start_o pulses once, cmd_busy_o = 1. A second write to adr 16 → error_o, no pulse. cmd_done_i for 1 cycle → busy = 0. Read adr 16 → 0.
- fifo_full_i = 1, write 0x55 to adr 17 → error_o, fifo_wr_en_o stays 0. fifo_full_i = 0 → one fifo_wr_en_o pulse with fifo_wr_data_o = 0x55, then ack.
- fifo_empty_i = 0, fifo_rd_data_i = 0x1234, read adr 18 → fifo_rd_en_o pulse, ack 2 cycles after the strobe with wb_data_o = 0x1234. With fifo_empty_i = 1 → error_o after 1 cycle.
- Access adr 21, read adr 17, write adr 18 → error_o each time. Strobe held high for 5 cycles → exactly one response.
- Assert reset during the data-exec ack cycle → ack_o, data_start_o and data_busy_o go to 0 immediately. With SD_WB_SLAVE_IRQ_EN: a data_done_i pulse raises irq_o, and a write to adr 15 clears it.
